// File: rtl/kuznechik_apb_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// kuznechik_apb_sequencer_pkg
// Shared definitions for the Kuznechik cipher APB wrapper and the sequencer
// that drives it: register byte offsets, CONTROL byte indices and the
// sequencer state type.
// -----------------------------------------------------------------------------
package kuznechik_apb_sequencer_pkg;

    // Register byte offsets relative to the wrapper base address.
    localparam logic [31:0] CONTROL  = 32'h0000_0000;
    localparam logic [31:0] DATA_IN  = 32'h0000_0010;  // four 32-bit words
    localparam logic [31:0] DATA_OUT = 32'h0000_0020;  // four 32-bit words

    // Byte lanes inside the CONTROL register.
    localparam int RST     = 0;
    localparam int REQ_ACK = 1;
    localparam int VALID   = 2;
    localparam int BUSY    = 3;

    // Value 1 placed in the least significant bit of a CONTROL byte lane.
    function automatic logic [31:0] ctrl_byte(input int idx);
        return 32'h1 << (idx * 8);
    endfunction

    // Write strobe covering one CONTROL byte lane.
    function automatic logic [3:0] ctrl_strb(input int idx);
        return 4'h1 << idx;
    endfunction

    // Request / acknowledge write: RST held at 1 (cipher out of reset) and REQ_ACK=1.
    localparam logic [31:0] REQ_WDATA = ctrl_byte(RST) | ctrl_byte(REQ_ACK);
    localparam logic [3:0]  REQ_STRB  = ctrl_strb(RST) | ctrl_strb(REQ_ACK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_WR_REQ,
        S_POLL,
        S_RD_DATA,
        S_WR_ACK,
        S_DONE,
        S_RECOVER
    } seq_state_t;

endpackage

// File: rtl/kuznechik_apb_master_port.sv
// -----------------------------------------------------------------------------
// kuznechik_apb_master_port
// Executes one APB transfer at a time. While start is high the transfer
// described by addr/wdata/strb/write is on the bus: the first cycle is SETUP,
// then ACCESS until pready. done pulses in the completing cycle; if start is
// still high in the following cycle the next SETUP begins at once.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, write, addr,        transfer request and its attributes
//   wdata, strb
//   done, rdata, err           completion pulse, read data, slave error
//   psel..pstrb                APB master outputs
//   pready, prdata, pslverr    APB master inputs
// -----------------------------------------------------------------------------
module kuznechik_apb_master_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  strb,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic        pready,
    input  logic [31:0] prdata,
    input  logic        pslverr
);

    logic access;

    // ACCESS follows SETUP and persists until the slave completes the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            access <= 1'b0;
        end else begin
            access <= start && !(access && pready);
        end
    end

    assign psel    = start;
    assign penable = access;
    assign pwrite  = start && write;
    assign paddr   = start ? addr : '0;
    assign pwdata  = (start && write) ? wdata : '0;
    assign pstrb   = (start && write) ? strb : '0;

    assign done  = access && pready;
    assign err   = access && pready && pslverr;
    assign rdata = prdata;

endmodule

// File: rtl/kuznechik_apb_sequencer.sv
// -----------------------------------------------------------------------------
// kuznechik_apb_sequencer
// Streams 128-bit blocks through the Kuznechik APB wrapper: writes DATA_IN,
// raises REQ, polls CONTROL for VALID, reads DATA_OUT, acknowledges and
// returns the result. Slave errors or a poll timeout run a cipher reset
// sequence and return an all-zero block flagged with out_err_o.
//
// Ports:
//   pclk_i, presetn_i                    clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i      plaintext stream
//   out_valid_o/out_ready_i/out_data_o/  result stream with error flag
//   out_err_o
//   busy_o                               sequencer not idle
//   paddr_o..pstrb_o, pready_i..pslverr_i APB master
// -----------------------------------------------------------------------------
module kuznechik_apb_sequencer
    import kuznechik_apb_sequencer_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic         pclk_i,
    input  logic         presetn_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         out_err_o,
    output logic         busy_o,
    output logic [31:0]  paddr_o,
    output logic         psel_o,
    output logic         penable_o,
    output logic         pwrite_o,
    output logic [31:0]  pwdata_o,
    output logic [3:0]   pstrb_o,
    input  logic         pready_i,
    input  logic [31:0]  prdata_i,
    input  logic         pslverr_i
);

    localparam int PW = $clog2(POLL_LIMIT + 1);

    seq_state_t     state, state_next;
    logic [127:0]   data_q;     // plaintext on the way in, result on the way out
    logic [1:0]     idx;        // word index; bit 0 doubles as RECOVER step
    logic [PW-1:0]  poll_cnt;
    logic           err_q;
    logic           run;        // keeps in_ready_o low until the first edge after reset

    logic           xfer_start, xfer_write, xfer_done, xfer_err;
    logic [31:0]    xfer_addr, xfer_wdata, xfer_rdata;
    logic [3:0]     xfer_strb;

    assign in_ready_o  = run && (state == S_IDLE);
    assign out_valid_o = (state == S_DONE);
    assign out_data_o  = data_q;
    assign out_err_o   = err_q;
    assign busy_o      = (state != S_IDLE);

    always_comb begin
        state_next = state;
        xfer_start = 1'b0;
        xfer_write = 1'b0;
        xfer_addr  = ADDR_BASE + CONTROL;
        xfer_wdata = '0;
        xfer_strb  = '0;
        case (state)
            S_IDLE: begin
                if (in_valid_i && in_ready_o) state_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                xfer_start = 1'b1;
                xfer_write = 1'b1;
                xfer_addr  = ADDR_BASE + DATA_IN + {28'd0, idx, 2'b00};
                xfer_wdata = data_q[{idx, 5'd0} +: 32];
                xfer_strb  = 4'hF;
                if (xfer_err)                    state_next = S_RECOVER;
                else if (xfer_done && idx == 2'd3) state_next = S_WR_REQ;
            end
            S_WR_REQ, S_WR_ACK: begin
                xfer_start = 1'b1;
                xfer_write = 1'b1;
                xfer_wdata = REQ_WDATA;
                xfer_strb  = REQ_STRB;
                if (xfer_err)       state_next = S_RECOVER;
                else if (xfer_done) state_next = (state == S_WR_REQ) ? S_POLL : S_DONE;
            end
            S_POLL: begin
                xfer_start = 1'b1;
                if (xfer_err)                                 state_next = S_RECOVER;
                else if (xfer_done && xfer_rdata[VALID * 8])  state_next = S_RD_DATA;
                else if (xfer_done && poll_cnt == PW'(POLL_LIMIT - 1)) state_next = S_RECOVER;
            end
            S_RD_DATA: begin
                xfer_start = 1'b1;
                xfer_addr  = ADDR_BASE + DATA_OUT + {28'd0, idx, 2'b00};
                if (xfer_err)                      state_next = S_RECOVER;
                else if (xfer_done && idx == 2'd3) state_next = S_WR_ACK;
            end
            S_RECOVER: begin
                // Pulse the cipher reset: RST byte 0, then back to 1.
                xfer_start = 1'b1;
                xfer_write = 1'b1;
                xfer_wdata = idx[0] ? ctrl_byte(RST) : '0;
                xfer_strb  = ctrl_strb(RST);
                if (xfer_done && idx[0]) state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state    <= S_IDLE;
            run      <= 1'b0;
            data_q   <= '0;
            idx      <= '0;
            poll_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        data_q   <= in_data_i;
                        idx      <= '0;
                        poll_cnt <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_WR_DATA: if (xfer_done) idx <= idx + 2'd1;
                S_POLL:    if (xfer_done) poll_cnt <= poll_cnt + PW'(1);
                S_RD_DATA: begin
                    if (xfer_done) begin
                        data_q[{idx, 5'd0} +: 32] <= xfer_rdata;
                        idx <= idx + 2'd1;
                    end
                end
                S_RECOVER: begin
                    if (xfer_done) begin
                        if (idx[0]) begin
                            data_q <= '0;
                            err_q  <= 1'b1;
                            idx    <= '0;
                        end else begin
                            idx <= 2'd1;
                        end
                    end
                end
                default: ;
            endcase
            // A failed transfer starts RECOVER at its first step.
            if (xfer_err && state != S_RECOVER) idx <= '0;
        end
    end

    kuznechik_apb_master_port u_port (
        .clk     (pclk_i),
        .rst_n   (presetn_i),
        .start   (xfer_start),
        .write   (xfer_write),
        .addr    (xfer_addr),
        .wdata   (xfer_wdata),
        .strb    (xfer_strb),
        .done    (xfer_done),
        .rdata   (xfer_rdata),
        .err     (xfer_err),
        .psel    (psel_o),
        .penable (penable_o),
        .pwrite  (pwrite_o),
        .paddr   (paddr_o),
        .pwdata  (pwdata_o),
        .pstrb   (pstrb_o),
        .pready  (pready_i),
        .prdata  (prdata_i),
        .pslverr (pslverr_i)
    );

endmodule

// File: tb/tb_kuznechik_apb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_kuznechik_apb_sequencer
// Scoreboard bench: each issued block pushes its expected APB transfer list
// and expected result into queues; the APB slave model and the output monitor
// pop and compare independently of the stimulus.
// -----------------------------------------------------------------------------
module tb_kuznechik_apb_sequencer;
    import kuznechik_apb_sequencer_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int          PL   = 8;

    logic         pclk, presetn;
    logic         in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [127:0] in_data, out_data;
    logic [31:0]  paddr, pwdata, prdata;
    logic         psel, penable, pwrite, pready, pslverr;
    logic [3:0]   pstrb;

    kuznechik_apb_sequencer #(.ADDR_BASE(BASE), .POLL_LIMIT(PL)) dut (
        .pclk_i      (pclk),
        .presetn_i   (presetn),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_err_o   (out_err),
        .busy_o      (busy),
        .paddr_o     (paddr),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .pwdata_o    (pwdata),
        .pstrb_o     (pstrb),
        .pready_i    (pready),
        .prdata_i    (prdata),
        .pslverr_i   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } xfer_t;

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           lat;
    } res_t;

    xfer_t exp_x[$];
    res_t  exp_r[$];

    int checks = 0;
    int errors = 0;

    // Slave configuration for the current block.
    int          cfg_wait, cfg_vpoll, cfg_err_at;
    bit          cfg_fixed, cfg_rec_err, apb_chk;
    int          s_cnt, s_polls;
    logic [31:0] s_din [4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired without a response, required a response", name);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Cipher stand-in used by the slave model: fixed words or a keyed rotate/xor.
    function automatic logic [31:0] slave_word(input logic [31:0] w, input int i, input bit fixed);
        if (fixed) return 32'h1111_1111 * 32'(i + 1);
        return {w[23:0], w[31:24]} ^ (32'h9E37_79B9 + 32'(i));
    endfunction

    // Reference model: transfer list and result derived from the block rules.
    task automatic plan_block(input logic [127:0] pt, input int w, input int vpoll,
                              input int err_at, input bit fixed);
        xfer_t       l[$];
        res_t        r;
        int          npoll;
        bit          failed;
        logic [31:0] reqw;
        logic [3:0]  reqs;
        reqw = (32'h1 << (8 * RST)) | (32'h1 << (8 * REQ_ACK));
        reqs = 4'((1 << RST) | (1 << REQ_ACK));
        for (int i = 0; i < 4; i++)
            l.push_back('{BASE + DATA_IN + 32'(4 * i), 1'b1, pt[32 * i +: 32], 4'hF});
        l.push_back('{BASE + CONTROL, 1'b1, reqw, reqs});
        npoll = (vpoll == 0) ? PL : vpoll;
        for (int i = 0; i < npoll; i++)
            l.push_back('{BASE + CONTROL, 1'b0, 32'h0, 4'h0});
        if (vpoll != 0) begin
            for (int i = 0; i < 4; i++)
                l.push_back('{BASE + DATA_OUT + 32'(4 * i), 1'b0, 32'h0, 4'h0});
            l.push_back('{BASE + CONTROL, 1'b1, reqw, reqs});
        end
        failed = (vpoll == 0) || (err_at != 0);
        if (err_at != 0)
            while (l.size() > err_at) void'(l.pop_back());
        if (failed) begin
            l.push_back('{BASE + CONTROL, 1'b1, 32'h0, 4'(1 << RST)});
            l.push_back('{BASE + CONTROL, 1'b1, 32'h1 << (8 * RST), 4'(1 << RST)});
        end
        r.err  = failed;
        r.data = '0;
        if (!failed)
            for (int i = 0; i < 4; i++) r.data[32 * i +: 32] = slave_word(pt[32 * i +: 32], i, fixed);
        r.lat = l.size() * (2 + w) + 1;
        foreach (l[k]) exp_x.push_back(l[k]);
        exp_r.push_back(r);
    endtask

    // APB slave model: decides completion mid-cycle and checks each transfer.
    initial begin : slave
        int          wcnt, k;
        logic [31:0] off, rd;
        bit          is_rec;
        xfer_t       e;
        wcnt = 0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (!presetn || !(psel && penable)) begin
                pready = 1'b0; pslverr = 1'b0; wcnt = 0;
            end else if (wcnt < cfg_wait) begin
                pready = 1'b0; wcnt++;
            end else begin
                wcnt = 0;
                off  = paddr - BASE;
                rd   = '0;
                s_cnt++;
                if (pwrite) begin
                    if (off >= DATA_IN && off < DATA_IN + 32'd16) s_din[int'((off - DATA_IN) >> 2)] = pwdata;
                end else if (off == CONTROL) begin
                    s_polls++;
                    rd = $urandom & ~(32'h1 << (8 * VALID));
                    if (cfg_vpoll != 0 && s_polls >= cfg_vpoll) rd = rd | (32'h1 << (8 * VALID));
                end else if (off >= DATA_OUT && off < DATA_OUT + 32'd16) begin
                    k  = int'((off - DATA_OUT) >> 2);
                    rd = slave_word(s_din[k], k, cfg_fixed);
                end
                is_rec  = pwrite && off == CONTROL && pstrb == 4'(1 << RST);
                prdata  = rd;
                pslverr = (s_cnt == cfg_err_at) || (is_rec && cfg_rec_err);
                pready  = 1'b1;
                if (apb_chk) begin
                    if (exp_x.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL apb_extra: got transfer addr %h write %0d, required none", paddr, pwrite);
                    end else begin
                        e = exp_x.pop_front();
                        check("apb_xfer", 128'({paddr, pwrite, pwdata, pstrb}),
                              128'({e.addr, e.wr, e.wdata, e.strb}));
                    end
                end
            end
        end
    end

    // Output monitor: latency, stability while stalled, result comparison.
    initial begin : monitor
        int           t_in, t_first;
        bit           seen;
        logic [127:0] held;
        res_t         e;
        t_in = 0; t_first = 0; seen = 1'b0; held = '0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                seen = 1'b0;
            end else begin
                if (in_valid && in_ready) t_in = cyc;
                if (out_valid) begin
                    if (!seen) begin
                        seen = 1'b1; t_first = cyc; held = out_data;
                    end else begin
                        check("out_data_stable", out_data, held);
                    end
                    check("in_ready_in_done", 128'(in_ready), 128'(0));
                    check("psel_in_done", 128'({psel, penable}), 128'(0));
                    if (out_ready) begin
                        seen = 1'b0;
                        if (exp_r.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_output: got %h, required no output", out_data);
                        end else begin
                            e = exp_r.pop_front();
                            check("out_data", out_data, e.data);
                            check("out_err", 128'(out_err), 128'(e.err));
                            check("latency", 128'(t_first - t_in), 128'(e.lat));
                        end
                    end
                end
            end
        end
    end

    task automatic run_block(input logic [127:0] pt, input int w, input int vpoll, input int err_at,
                             input bit fixed, input bit rec_err, input int hold, input bit abort);
        int n;
        bit hs;
        cfg_wait = w; cfg_vpoll = vpoll; cfg_err_at = err_at;
        cfg_fixed = fixed; cfg_rec_err = rec_err; s_cnt = 0; s_polls = 0;
        apb_chk = !abort;
        if (!abort) plan_block(pt, w, vpoll, err_at, fixed);
        in_valid = 1'b1;
        in_data  = pt;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin
            hs = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!hs) begin
            fail_bound("in_handshake");
            return;
        end
        if (abort) begin
            n = 0;
            while (!(psel && !pwrite && paddr == BASE + CONTROL) && n < 200) begin
                tick();
                n++;
            end
            if (n == 200) fail_bound("reach_poll");
            #2 presetn = 1'b0;
            #1 check("reset_in_poll", 128'({psel, penable, pwrite, busy, out_valid, in_ready, paddr}), 128'(0));
            tick();
            check("reset_held", 128'({psel, busy, in_ready, out_err, pwdata, pstrb}), 128'(0));
            presetn = 1'b1;
            tick();
            check("ready_after_release", 128'({in_ready, busy}), 128'(2'b10));
            apb_chk = 1'b1;
            return;
        end
        n = 0;
        while (!out_valid && n < 5000) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            fail_bound("out_valid_timeout");
            exp_x.delete();
            exp_r.delete();
            return;
        end
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [127:0] pt;
        int           vp;
        presetn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cfg_wait = 0; cfg_vpoll = 0; cfg_err_at = 0; cfg_fixed = 1'b0; cfg_rec_err = 1'b0;
        apb_chk = 1'b1; s_cnt = 0; s_polls = 0;
        repeat (3) @(negedge pclk);
        check("reset_ctrl", 128'({psel, penable, pwrite, in_ready, out_valid, out_err, busy}), 128'(0));
        check("reset_bus", 128'({paddr, pwdata, pstrb}), 128'(0));
        check("reset_out_data", out_data, 128'(0));
        @(posedge pclk);
        #1 presetn = 1'b1;
        check("ready_before_edge", 128'(in_ready), 128'(0));
        tick();
        check("ready_first_edge", 128'(in_ready), 128'(1));

        pt = 128'hfedcba98_76543210_01234567_89abcdef;
        run_block(pt, 0, 3, 0, 1'b1, 1'b0, 0, 1'b0);   // zero-wait, VALID on 3rd poll
        run_block(pt, 2, 3, 0, 1'b1, 1'b0, 0, 1'b0);   // two wait states
        run_block(pt, 0, 3, 2, 1'b1, 1'b1, 0, 1'b0);   // slave error on 2nd DATA_IN write
        run_block(pt, 1, 0, 0, 1'b1, 1'b0, 0, 1'b0);   // VALID never set
        run_block(pt, 0, 2, 0, 1'b0, 1'b0, 5, 1'b0);   // consumer stalls 5 cycles
        run_block(pt, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1);   // reset while polling

        for (int b = 0; b < 20; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            run_block(pt, $urandom_range(0, 2), $urandom_range(1, PL), 0, 1'b0, 1'b0,
                      $urandom_range(0, 2), 1'b0);
        end
        for (int b = 0; b < 4; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            vp = $urandom_range(1, PL);
            run_block(pt, $urandom_range(0, 1), vp, $urandom_range(1, 10 + vp), 1'b0,
                      1'($urandom_range(0, 1)), 0, 1'b0);
        end

        repeat (5) tick();
        check("pending_results", 128'(exp_r.size()), 128'(0));
        check("pending_xfers", 128'(exp_x.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
